// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbiter and access sequencer for the unified instruction/data memory of the
// multicycle accumulator CPU. The memory is shared between the CPU controller
// and an external loader/debug port. The arbiter latches the winning request
// and drives the memory for MEM_LAT cycles. It then returns read data together
// with a one-cycle acknowledge.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin tie break (alternates on saturating requesters)
//   undefined -> fixed priority, the CPU wins every tie
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request, held stable until cpu_ack
//   cpu_rdata, cpu_ack         CPU read data (valid with ack), one-cycle ack
//   cpu_stall                  cpu_req & ~cpu_ack, freezes the controller
//   ext_req/we/addr/wdata      external port request, same rules as the CPU
//   ext_rdata, ext_ack         external read data and one-cycle ack
//   mem_en/we/addr/wdata       registered memory strobes and operands
//   mem_rdata                  memory read data
//   owner_ext                  current or last grant went to the external port
//   busy                       arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_stall,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic [DW-1:0] ext_rdata,
   output logic          ext_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner_ext,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Counter counts down from MEM_LAT-1 to 0; the access ends on the zero cycle.
   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          owner_ext_q, owner_ext_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          ext_ack_q, ext_ack_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] ext_rdata_q, ext_rdata_d;
   logic          tie_to_ext;
   logic          grant_ext;

   // Who wins when both sides request in the same IDLE cycle.
`ifdef MEM_ARB_RR_EN
   // owner_ext names the last winner, so the other side takes the tie.
   assign tie_to_ext = ~owner_ext_q;
`else
   assign tie_to_ext = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the case statement can leave it unassigned and infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      owner_ext_d = owner_ext_q;
      cpu_rdata_d = cpu_rdata_q;
      ext_rdata_d = ext_rdata_q;
      grant_ext   = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_req || ext_req) begin
               grant_ext   = ext_req & (~cpu_req | tie_to_ext);
               owner_ext_d = grant_ext;
               we_d        = grant_ext ? ext_we    : cpu_we;
               addr_d      = grant_ext ? ext_addr  : cpu_addr;
               wdata_d     = grant_ext ? ext_wdata : cpu_wdata;
               cnt_d       = CNT_LOAD;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Final access cycle: memory data is valid at this closing edge.
               if (!we_q) begin
                  if (owner_ext_q) ext_rdata_d = mem_rdata;
                  else             cpu_rdata_d = mem_rdata;
               end
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Strobes and acks are computed from the next state and registered, so
      // the memory sees glitch-free, state-aligned signals.
      mem_en_d  = (state_d == ACCESS);
      mem_we_d  = (state_d == ACCESS) & we_d;
      cpu_ack_d = (state_d == DONE) & ~owner_ext_d;
      ext_ack_d = (state_d == DONE) &  owner_ext_d;
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         owner_ext_q <= 1'b1;   // CPU wins the first tie under round-robin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         cpu_ack_q   <= 1'b0;
         ext_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         owner_ext_q <= owner_ext_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         cpu_ack_q   <= cpu_ack_d;
         ext_ack_q   <= ext_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         ext_rdata_q <= ext_rdata_d;
      end
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_stall = cpu_req & ~cpu_ack_q;
   assign ext_rdata = ext_rdata_q;
   assign ext_ack   = ext_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign owner_ext = owner_ext_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A MEM_LAT=2 instance is exercised with a
// per-cycle vector table, hand-written tie/reset sequences and a randomized run
// checked against a transaction-timeline model. A MEM_LAT=1 instance covers the
// short-latency timing.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int LAT = 2;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- main instance (MEM_LAT = 2) ----------------
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [7:0]  cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        cpu_ack, cpu_stall;
   logic        ext_req = 1'b0, ext_we = 1'b0;
   logic [7:0]  ext_addr = '0;
   logic [15:0] ext_wdata = '0;
   logic [15:0] ext_rdata;
   logic        ext_ack;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        owner_ext, busy;

   mem_arbiter #(.AW(8), .DW(16), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata), .ext_ack(ext_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner_ext(owner_ext), .busy(busy)
   );

   // ---------------- short-latency instance (MEM_LAT = 1) ----------------
   logic        l1_cpu_req = 1'b0;
   logic [7:0]  l1_cpu_addr = '0;
   logic [15:0] l1_cpu_rdata, l1_ext_rdata, l1_mem_wdata, l1_mem_rdata;
   logic        l1_cpu_ack, l1_cpu_stall, l1_ext_ack, l1_mem_en, l1_mem_we;
   logic        l1_owner_ext, l1_busy;
   logic [7:0]  l1_mem_addr;

   mem_arbiter #(.AW(8), .DW(16), .MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset),
      .cpu_req(l1_cpu_req), .cpu_we(1'b0), .cpu_addr(l1_cpu_addr), .cpu_wdata(16'h0),
      .cpu_rdata(l1_cpu_rdata), .cpu_ack(l1_cpu_ack), .cpu_stall(l1_cpu_stall),
      .ext_req(1'b0), .ext_we(1'b0), .ext_addr(8'h0), .ext_wdata(16'h0),
      .ext_rdata(l1_ext_rdata), .ext_ack(l1_ext_ack),
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
      .mem_rdata(l1_mem_rdata), .owner_ext(l1_owner_ext), .busy(l1_busy)
   );

   // ---------------- memory environment ----------------
   function automatic logic [15:0] init_val(input logic [7:0] a);
      if (a == 8'h10) return 16'h1234;
      return {a, ~a};
   endfunction

   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata    = mem[mem_addr];
   assign l1_mem_rdata = init_val(l1_mem_addr);

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        c_req, c_we;
      logic [7:0]  c_addr;
      logic [15:0] c_wd;
      logic        e_req, e_we;
      logic [7:0]  e_addr;
      logic [15:0] e_wd;
      logic        x_en, x_we, x_cack, x_eack, x_stall, x_busy, x_owner;
      logic [7:0]  x_addr;
      logic [15:0] x_rdata;
   } vec_t;

   // fl = {mem_en, mem_we, cpu_ack, ext_ack, cpu_stall, busy, owner_ext}
   function automatic vec_t mk(input logic cr, input logic cw, input logic [7:0] ca,
                               input logic [15:0] cd, input logic er, input logic ew,
                               input logic [7:0] ea, input logic [15:0] ed,
                               input logic [6:0] fl, input logic [7:0] xa,
                               input logic [15:0] rd);
      vec_t v;
      v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
      v.e_req = er; v.e_we = ew; v.e_addr = ea; v.e_wd = ed;
      v.x_en = fl[6]; v.x_we = fl[5]; v.x_cack = fl[4]; v.x_eack = fl[3];
      v.x_stall = fl[2]; v.x_busy = fl[1]; v.x_owner = fl[0];
      v.x_addr = xa; v.x_rdata = rd;
      return v;
   endfunction

   vec_t tbl [23];

   // random-run model state
   logic [15:0] ref_mem [256];
   int          grant;
   logic        g_ext, g_we;
   logic [7:0]  g_addr;
   logic [15:0] g_wdata, g_rdata;
   logic        owner_exp;
   logic [15:0] crd_exp, erd_exp;
   logic        c_ackd, e_ackd;

   initial begin
      // ---- table: read, write/read-back, request during access ----
      tbl[0]  = mk(1'b1,1'b0,8'h10,'0, 1'b0,1'b0,8'h00,'0,     7'b0000101, 8'h10, '0);
      tbl[1]  = mk(1'b1,1'b0,8'h10,'0, 1'b0,1'b0,8'h00,'0,     7'b1000110, 8'h10, '0);
      tbl[2]  = mk(1'b1,1'b0,8'h10,'0, 1'b0,1'b0,8'h00,'0,     7'b1000110, 8'h10, '0);
      tbl[3]  = mk(1'b1,1'b0,8'h10,'0, 1'b0,1'b0,8'h00,'0,     7'b0010010, 8'h10, 16'h1234);
      tbl[4]  = mk(1'b0,1'b0,8'h00,'0, 1'b0,1'b0,8'h00,'0,     7'b0000000, 8'h00, '0);
      tbl[5]  = mk(1'b0,1'b0,8'h00,'0, 1'b1,1'b1,8'h20,16'hBEEF, 7'b0000000, 8'h20, '0);
      tbl[6]  = mk(1'b0,1'b0,8'h00,'0, 1'b1,1'b1,8'h20,16'hBEEF, 7'b1100011, 8'h20, '0);
      tbl[7]  = mk(1'b0,1'b0,8'h00,'0, 1'b1,1'b1,8'h20,16'hBEEF, 7'b1100011, 8'h20, '0);
      tbl[8]  = mk(1'b0,1'b0,8'h00,'0, 1'b1,1'b1,8'h20,16'hBEEF, 7'b0001011, 8'h20, '0);
      tbl[9]  = mk(1'b1,1'b0,8'h20,'0, 1'b0,1'b0,8'h00,'0,     7'b0000101, 8'h20, '0);
      tbl[10] = mk(1'b1,1'b0,8'h20,'0, 1'b0,1'b0,8'h00,'0,     7'b1000110, 8'h20, '0);
      tbl[11] = mk(1'b1,1'b0,8'h20,'0, 1'b0,1'b0,8'h00,'0,     7'b1000110, 8'h20, '0);
      tbl[12] = mk(1'b1,1'b0,8'h20,'0, 1'b0,1'b0,8'h00,'0,     7'b0010010, 8'h20, 16'hBEEF);
      tbl[13] = mk(1'b0,1'b0,8'h00,'0, 1'b0,1'b0,8'h00,'0,     7'b0000000, 8'h00, '0);
      tbl[14] = mk(1'b1,1'b0,8'h10,'0, 1'b0,1'b0,8'h00,'0,     7'b0000100, 8'h10, '0);
      tbl[15] = mk(1'b1,1'b0,8'h10,'0, 1'b1,1'b0,8'h20,'0,     7'b1000110, 8'h10, '0);
      tbl[16] = mk(1'b1,1'b0,8'h10,'0, 1'b1,1'b0,8'h20,'0,     7'b1000110, 8'h10, '0);
      tbl[17] = mk(1'b1,1'b0,8'h10,'0, 1'b1,1'b0,8'h20,'0,     7'b0010010, 8'h10, 16'h1234);
      tbl[18] = mk(1'b0,1'b0,8'h00,'0, 1'b1,1'b0,8'h20,'0,     7'b0000000, 8'h20, '0);
      tbl[19] = mk(1'b0,1'b0,8'h00,'0, 1'b1,1'b0,8'h20,'0,     7'b1000011, 8'h20, '0);
      tbl[20] = mk(1'b0,1'b0,8'h00,'0, 1'b1,1'b0,8'h20,'0,     7'b1000011, 8'h20, '0);
      tbl[21] = mk(1'b0,1'b0,8'h00,'0, 1'b1,1'b0,8'h20,'0,     7'b0001011, 8'h20, 16'hBEEF);
      tbl[22] = mk(1'b0,1'b0,8'h00,'0, 1'b0,1'b0,8'h00,'0,     7'b0000001, 8'h00, '0);

      // ---- reset values ----
      reset = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("rst_cpu_ack",   cpu_ack,   0);
      check("rst_ext_ack",   ext_ack,   0);
      check("rst_mem_en",    mem_en,    0);
      check("rst_mem_we",    mem_we,    0);
      check("rst_mem_addr",  mem_addr,  0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_ext_rdata", ext_rdata, 0);
      check("rst_owner_ext", owner_ext, 1);
      check("rst_busy",      busy,      0);
      next_cycle();
      reset = 1'b0;

      // ---- table-driven vectors ----
      for (int i = 0; i < 23; i++) begin
         cpu_req = tbl[i].c_req; cpu_we = tbl[i].c_we;
         cpu_addr = tbl[i].c_addr; cpu_wdata = tbl[i].c_wd;
         ext_req = tbl[i].e_req; ext_we = tbl[i].e_we;
         ext_addr = tbl[i].e_addr; ext_wdata = tbl[i].e_wd;
         @(negedge clk);
         check($sformatf("t%0d_mem_en", i),    mem_en,    tbl[i].x_en);
         check($sformatf("t%0d_mem_we", i),    mem_we,    tbl[i].x_we);
         check($sformatf("t%0d_cpu_ack", i),   cpu_ack,   tbl[i].x_cack);
         check($sformatf("t%0d_ext_ack", i),   ext_ack,   tbl[i].x_eack);
         check($sformatf("t%0d_cpu_stall", i), cpu_stall, tbl[i].x_stall);
         check($sformatf("t%0d_busy", i),      busy,      tbl[i].x_busy);
         check($sformatf("t%0d_owner", i),     owner_ext, tbl[i].x_owner);
         if (tbl[i].x_en)   check($sformatf("t%0d_mem_addr", i),  mem_addr,  tbl[i].x_addr);
         if (tbl[i].x_cack) check($sformatf("t%0d_cpu_rdata", i), cpu_rdata, tbl[i].x_rdata);
         if (tbl[i].x_eack) check($sformatf("t%0d_ext_rdata", i), ext_rdata, tbl[i].x_rdata);
         next_cycle();
      end

      // ---- both requesters saturating ----
      begin
         logic [3:0] exp_order;
         int n_ack = 0, cyc = 0, last = 0;
         logic ca, ea;
         exp_order = RR ? 4'b1010 : 4'b0000;   // bit k = 1 when transfer k goes to ext
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
         ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h20;
         while (cyc < 100 && (cpu_req || ext_req || busy)) begin
            @(negedge clk);
            ca = cpu_ack;
            ea = ext_ack;
            if (ca || ea) begin
               if (n_ack < 4) begin
                  check($sformatf("tie_order%0d", n_ack), ea, exp_order[n_ack]);
                  if (n_ack > 0) check($sformatf("tie_gap%0d", n_ack), cyc - last, LAT + 2);
                  if (ca) check("tie_cpu_rdata", cpu_rdata, 16'h1234);
                  if (ea) check("tie_ext_rdata", ext_rdata, 16'hBEEF);
                  last = cyc;
               end
               n_ack++;
            end
            next_cycle();
            cyc++;
            if (ca && n_ack >= 4) cpu_req = 1'b0;
            if (ea && n_ack >= 4) ext_req = 1'b0;
         end
         check("tie_no_timeout", cyc < 100, 1);
         check("tie_ack_count", n_ack >= 4, 1);
      end

      // ---- reset during the first ACCESS cycle of a CPU write ----
      begin
         int k = 0;
         cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'hA5A5;
         ext_req = 1'b0;
         @(negedge clk);
         check("rw_idle_busy", busy, 0);
         next_cycle();
         reset = 1'b1;
         @(negedge clk);
         check("rw_access_en", mem_en, 1);
         check("rw_access_we", mem_we, 1);
         next_cycle();
         reset = 1'b0;
         @(negedge clk);
         check("rw_after_busy",   busy,      0);
         check("rw_after_en",     mem_en,    0);
         check("rw_after_we",     mem_we,    0);
         check("rw_after_ack",    cpu_ack,   0);
         check("rw_after_owner",  owner_ext, 1);
         check("rw_after_stall",  cpu_stall, 1);
         while (k < 20) begin
            next_cycle();
            k++;
            @(negedge clk);
            if (cpu_ack) break;
         end
         check("rw_regrant_latency", k, LAT + 1);
         next_cycle();
         cpu_req = 1'b0; cpu_we = 1'b0;
      end

      // ---- MEM_LAT = 1 instance: latency and back-to-back spacing ----
      begin
         int acks = 0, cyc = 0, last_ack = 0;
         logic [7:0] a = 8'h10;
         l1_cpu_addr = a;
         l1_cpu_req  = 1'b1;
         while (acks < 3 && cyc < 30) begin
            @(negedge clk);
            if (l1_cpu_ack) begin
               check($sformatf("l1_rdata%0d", acks), l1_cpu_rdata, init_val(a));
               check($sformatf("l1_spacing%0d", acks), cyc - last_ack, (acks == 0) ? 2 : 3);
               last_ack = cyc;
               acks++;
               a = a + 8'd1;
               next_cycle();
               l1_cpu_addr = a;
            end else begin
               next_cycle();
            end
            cyc++;
         end
         l1_cpu_req = 1'b0;
         check("l1_ack_count", acks, 3);
      end

      // ---- randomized run against a transaction-timeline model ----
      reset = 1'b1;
      cpu_req = 1'b0; ext_req = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      for (int a = 0; a < 256; a++) ref_mem[a] = init_val(8'(a));
      grant = -100;
      g_ext = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0; g_rdata = '0;
      owner_exp = 1'b1; crd_exp = '0; erd_exp = '0;
      c_ackd = 1'b0; e_ackd = 1'b0;
      for (int t = 0; t < 600; t++) begin
         logic in_acc, in_done;
         if (!cpu_req || c_ackd) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_addr  = 8'($urandom_range(0, 7));
            cpu_wdata = 16'($urandom);
         end
         if (!ext_req || e_ackd) begin
            ext_req   = ($urandom_range(0, 1) != 0);
            ext_we    = ($urandom_range(0, 1) == 0);
            ext_addr  = 8'($urandom_range(0, 7));
            ext_wdata = 16'($urandom);
         end
         @(negedge clk);
         // a transfer granted in cycle g occupies g+1..g+LAT and acks at g+LAT+1
         in_acc  = (t > grant) && (t <= grant + LAT);
         in_done = (t == grant + LAT + 1);
         if (in_done && !g_we) begin
            if (g_ext) erd_exp = g_rdata;
            else       crd_exp = g_rdata;
         end
         check("rnd_mem_en",    mem_en,    in_acc);
         check("rnd_mem_we",    mem_we,    in_acc && g_we);
         check("rnd_busy",      busy,      in_acc || in_done);
         check("rnd_cpu_ack",   cpu_ack,   in_done && !g_ext);
         check("rnd_ext_ack",   ext_ack,   in_done && g_ext);
         check("rnd_cpu_stall", cpu_stall, cpu_req && !(in_done && !g_ext));
         check("rnd_owner",     owner_ext, owner_exp);
         check("rnd_cpu_rdata", cpu_rdata, crd_exp);
         check("rnd_ext_rdata", ext_rdata, erd_exp);
         if (in_acc) check("rnd_mem_addr", mem_addr, g_addr);
         if (in_acc && g_we) check("rnd_mem_wdata", mem_wdata, g_wdata);
         c_ackd = in_done && !g_ext;
         e_ackd = in_done && g_ext;
         if (t >= grant + LAT + 2 && (cpu_req || ext_req)) begin
            g_ext   = ext_req && (!cpu_req || (RR && !owner_exp));
            g_we    = g_ext ? ext_we    : cpu_we;
            g_addr  = g_ext ? ext_addr  : cpu_addr;
            g_wdata = g_ext ? ext_wdata : cpu_wdata;
            grant   = t;
            owner_exp = g_ext;
            if (g_we) ref_mem[g_addr] = g_wdata;
            else      g_rdata = ref_mem[g_addr];
         end
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
